lms_ctr_oc_mem_loader: RTL

- Avalon-MM write master that drives the 8192x32 single-port on-chip memory slave of the lms_ctr system.
- Accepts a 32-bit word stream (valid/ready) and writes it to consecutive word addresses from a programmed base.
- Accumulates a 32-bit additive checksum of the words it writes.
- Optionally reads the region back and compares checksums, so firmware/tables can be loaded and verified before the CPU runs.

---
 rtl/lms_ctr_oc_mem_pkg.sv | 30 +++
 rtl/lms_ctr_oc_mem_addr_gen.sv | 57 +++++
 rtl/lms_ctr_oc_mem_loader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/lms_ctr_oc_mem_pkg.sv
// -----------------------------------------------------------------------------
// lms_ctr_oc_mem_pkg
// Shared constants and state encoding for the lms_ctr on-chip memory loader.
//   ADDR_W / DATA_W / DEPTH : geometry of the 8192x32 target memory
//   BE_ALL                  : byteenable value for every access
//   DEPTH_CNT               : DEPTH expressed in the word_cnt width
//   state_t + ST_*          : loader FSM encoding
// Address arithmetic wraps by truncation to ADDR_W bits, which equals
// "mod DEPTH" only because DEPTH == 2**ADDR_W.
// -----------------------------------------------------------------------------
package lms_ctr_oc_mem_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8192;
  localparam int BE_W   = DATA_W / 8;

  localparam logic [BE_W-1:0]   BE_ALL    = '1;
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_WRITE    = 3'd1;
  localparam state_t ST_RD_ISSUE = 3'd2;
  localparam state_t ST_RD_DRAIN = 3'd3;
  localparam state_t ST_CHECK    = 3'd4;
  localparam state_t ST_FINISH   = 3'd5;

endpackage

// File: rtl/lms_ctr_oc_mem_addr_gen.sv
// -----------------------------------------------------------------------------
// lms_ctr_oc_mem_addr_gen
// Loadable word-offset counter shared by the write and readback phases.
//   clk, reset  : clock, asynchronous active-high reset
//   load        : capture load_base/load_cnt and clear the offset
//   rewind      : clear the offset, keep base and count (start of readback)
//   step        : advance the offset by one word
//   addr        : base + offset, wrapping modulo DEPTH
//   last        : the current offset is the final word of the job
//   more        : words remain (offset has not yet reached the count)
// -----------------------------------------------------------------------------
module lms_ctr_oc_mem_addr_gen
  import lms_ctr_oc_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_cnt,
  input  logic              rewind,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              more
);

  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W:0]   cnt_reg;
  logic [ADDR_W:0]   offset_reg;
  logic [ADDR_W:0]   offset_inc;

  assign offset_inc = offset_reg + (ADDR_W + 1)'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_reg   <= '0;
      cnt_reg    <= '0;
      offset_reg <= '0;
    end else if (load) begin
      base_reg   <= load_base;
      cnt_reg    <= load_cnt;
      offset_reg <= '0;
    end else if (rewind) begin
      // rewind wins over a simultaneous step: the last write hands over
      // directly to the first read address
      offset_reg <= '0;
    end else if (step) begin
      offset_reg <= offset_inc;
    end
  end

  // Truncating the sum to ADDR_W bits is the modulo-DEPTH wrap
  assign addr = base_reg + offset_reg[ADDR_W-1:0];
  assign last = (offset_inc == cnt_reg);
  assign more = (offset_reg != cnt_reg);

endmodule

// File: rtl/lms_ctr_oc_mem_loader.sv
// -----------------------------------------------------------------------------
// lms_ctr_oc_mem_loader
// Avalon-MM write master that streams 32-bit words into the lms_ctr 8192x32
// on-chip memory at consecutive addresses from a programmed base, keeping an
// additive checksum of everything written.
//
// Optional feature macro: OC_MEM_LOADER_VERIFY_EN
//   defined   : after the write pass the region is read back, summed and
//               compared with the checksum; a mismatch sets error
//   undefined : the job finishes right after the write pass, avm_readdata
//               is ignored
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   start             : one-cycle pulse, latches base_addr/word_cnt when idle
//   abort             : level, terminates an active job with error
//   base_addr         : first word address
//   word_cnt          : number of words, 0..DEPTH (larger -> error)
//   s_data/s_valid/s_ready : input word stream
//   busy, done, error : job status (done is a pulse, error is sticky)
//   checksum          : running sum of written words
//   avm_*             : Avalon-MM master to the memory slave
// -----------------------------------------------------------------------------
module lms_ctr_oc_mem_loader
  import lms_ctr_oc_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_cnt,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] avm_address,
  output logic [BE_W-1:0]   avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              avm_clken
);

`ifdef OC_MEM_LOADER_VERIFY_EN
  localparam state_t ST_AFTER_WRITE = ST_RD_ISSUE;
`else
  localparam state_t ST_AFTER_WRITE = ST_FINISH;
`endif

  state_t            state_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              error_reg;
  logic              clken_reg;
  logic [DATA_W-1:0] checksum_reg;
  logic              cs_reg;
  logic              wr_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;

  logic              ag_load;
  logic              ag_rewind;
  logic              ag_step;
  logic [ADDR_W-1:0] ag_addr;
  logic              ag_last;
  logic              ag_more;
  logic              ready_int;
  logic              accept;

`ifdef OC_MEM_LOADER_VERIFY_EN
  // rd_valid_reg marks the cycle in which avm_readdata answers the read
  // address that was on the bus one cycle earlier
  logic              rd_valid_reg;
  logic [DATA_W-1:0] rd_sum_reg;
  logic [DATA_W-1:0] rd_sum_next;

  assign rd_sum_next = rd_valid_reg ? (rd_sum_reg + avm_readdata) : rd_sum_reg;
`else
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata;
`endif

  // abort gates ready so a word offered in the abort cycle is never taken
  assign ready_int = (state_reg == ST_WRITE) && ag_more && !abort;
  assign accept    = s_valid && ready_int;

  assign ag_load = (state_reg == ST_IDLE) && start;
  assign ag_step = accept || ((state_reg == ST_RD_ISSUE) && !abort);
`ifdef OC_MEM_LOADER_VERIFY_EN
  assign ag_rewind = accept && ag_last;
`else
  assign ag_rewind = 1'b0;
`endif

  lms_ctr_oc_mem_addr_gen u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (ag_load),
    .load_base (base_addr),
    .load_cnt  (word_cnt),
    .rewind    (ag_rewind),
    .step      (ag_step),
    .addr      (ag_addr),
    .last      (ag_last),
    .more      (ag_more)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
      clken_reg    <= 1'b0;
      checksum_reg <= '0;
      cs_reg       <= 1'b0;
      wr_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
`ifdef OC_MEM_LOADER_VERIFY_EN
      rd_valid_reg <= 1'b0;
      rd_sum_reg   <= '0;
`endif
    end else begin
      clken_reg <= 1'b1;
      done_reg  <= 1'b0;
      // bus strobes are single-cycle unless a state re-arms them below
      cs_reg    <= 1'b0;
      wr_reg    <= 1'b0;
`ifdef OC_MEM_LOADER_VERIFY_EN
      rd_valid_reg <= cs_reg && !wr_reg;
      if (rd_valid_reg) begin
        rd_sum_reg <= rd_sum_next;
      end
`endif
      if (abort && (state_reg != ST_IDLE)) begin
        // the access already registered for this cycle still goes out;
        // nothing new is issued
        error_reg <= 1'b1;
        if (state_reg == ST_FINISH) begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end else begin
          state_reg <= ST_FINISH;
        end
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start) begin
              busy_reg     <= 1'b1;
              checksum_reg <= '0;
              error_reg    <= (word_cnt > DEPTH_CNT);
`ifdef OC_MEM_LOADER_VERIFY_EN
              rd_sum_reg   <= '0;
`endif
              if ((word_cnt == '0) || (word_cnt > DEPTH_CNT)) begin
                state_reg <= ST_FINISH;
              end else begin
                state_reg <= ST_WRITE;
              end
            end
          end
          ST_WRITE: begin
            if (accept) begin
              cs_reg       <= 1'b1;
              wr_reg       <= 1'b1;
              addr_reg     <= ag_addr;
              wdata_reg    <= s_data;
              checksum_reg <= checksum_reg + s_data;
              if (ag_last) begin
                state_reg <= ST_AFTER_WRITE;
              end
            end
          end
`ifdef OC_MEM_LOADER_VERIFY_EN
          ST_RD_ISSUE: begin
            cs_reg   <= 1'b1;
            addr_reg <= ag_addr;
            if (ag_last) begin
              state_reg <= ST_RD_DRAIN;
            end
          end
          ST_RD_DRAIN: begin
            state_reg <= ST_CHECK;
          end
          ST_CHECK: begin
            // the final read word arrives this cycle, so compare against
            // the sum that includes it
            if (rd_sum_next != checksum_reg) begin
              error_reg <= 1'b1;
            end
            state_reg <= ST_FINISH;
          end
`endif
          ST_FINISH: begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign s_ready        = ready_int;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign error          = error_reg;
  assign checksum       = checksum_reg;
  assign avm_address    = addr_reg;
  assign avm_chipselect = cs_reg;
  assign avm_write      = wr_reg;
  assign avm_writedata  = wdata_reg;
  assign avm_byteenable = cs_reg ? BE_ALL : '0;
  assign avm_clken      = clken_reg;

endmodule
